// File: rtl/pipeline_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//   Bundles the hazard-relevant pipeline fields and the stall/flush controls
//   exchanged between the 5-stage datapath and pipeline_hazard_ctrl.
//   Parameter: REG_W - register-address width.
//   Modports:
//     master - datapath side: drives pipeline status, receives controls
//     slave  - controller side: samples pipeline status, drives controls
// ----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = 3
);
    // Pipeline status (datapath -> controller)
    logic [REG_W-1:0] ifid_rs;
    logic [REG_W-1:0] ifid_rt;
    logic             ifid_uses_rt;
    logic             idex_mem_read;
    logic [REG_W-1:0] idex_wr_reg;
    logic             exmem_branch;
    logic             exmem_zero;
    logic             exmem_mem_rd;
    logic             exmem_mem_wr;
    logic             mem_ready;

    // Pipeline controls (controller -> datapath)
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_bubble;
    logic             pipe_hold;
    logic             memwb_bubble;
    logic             pc_src;
    logic             mem_timeout;

    modport master (
        output ifid_rs, ifid_rt, ifid_uses_rt, idex_mem_read, idex_wr_reg,
               exmem_branch, exmem_zero, exmem_mem_rd, exmem_mem_wr, mem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, exmem_bubble,
               pipe_hold, memwb_bubble, pc_src, mem_timeout
    );

    modport slave (
        input  ifid_rs, ifid_rt, ifid_uses_rt, idex_mem_read, idex_wr_reg,
               exmem_branch, exmem_zero, exmem_mem_rd, exmem_mem_wr, mem_ready,
        output pc_write, ifid_write, ifid_flush, idex_bubble, exmem_bubble,
               pipe_hold, memwb_bubble, pc_src, mem_timeout
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Hazard/sequencing controller for the 5-stage 16-bit pipeline. Stalls on
//   load-use hazards, flushes IF/ID, ID/EX and EX/MEM on a taken branch
//   resolved in MEM, freezes the pipeline while data memory is busy, and
//   latches a sticky error when a memory access exceeds TIMEOUT wait cycles.
//   All state changes on the falling clock edge, the same edge the pipeline
//   registers use; the controls themselves are combinational.
//
//   Ports:
//     clk        - clock (state on negedge)
//     rst_n      - synchronous active-low reset
//     hz         - pipeline_hazard_ctrl_if.slave (status in, controls out)
//     stall_cnt  - cycles with pc_write=0 (saturating)
//     flush_cnt  - taken branches (saturating)
//
//   Optional feature: define HAZ_PERF_CNT_EN to build the saturating
//   stall/flush counters; otherwise both outputs are tied to zero.
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int REG_W   = 3,
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_hazard_ctrl_if.slave hz,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    logic mem_busy;
    logic branch_taken;
    logic load_use;

    assign mem_busy     = (hz.exmem_mem_rd | hz.exmem_mem_wr) & ~hz.mem_ready;
    assign branch_taken = hz.exmem_branch & hz.exmem_zero;
    // r0 is deliberately not exempt: a load to r0 still stalls its consumer.
    assign load_use     = hz.idex_mem_read &
                          ((hz.idex_wr_reg == hz.ifid_rs) |
                           (hz.ifid_uses_rt & (hz.idex_wr_reg == hz.ifid_rt)));

    // Next state and controls. Priority: ERR > mem wait > branch > load-use.
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_d         = state_q;
        to_cnt_d        = to_cnt_q;
        hz.pc_write     = 1'b1;
        hz.ifid_write   = 1'b1;
        hz.ifid_flush   = 1'b0;
        hz.idex_bubble  = 1'b0;
        hz.exmem_bubble = 1'b0;
        hz.pipe_hold    = 1'b0;
        hz.memwb_bubble = 1'b0;
        hz.pc_src       = 1'b0;
        hz.mem_timeout  = 1'b0;

        case (state_q)
            ST_ERR: begin
                // Frozen until reset.
                hz.pc_write     = 1'b0;
                hz.ifid_write   = 1'b0;
                hz.pipe_hold    = 1'b1;
                hz.memwb_bubble = 1'b1;
                hz.mem_timeout  = 1'b1;
            end
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_busy) begin
                    hz.pc_write     = 1'b0;
                    hz.ifid_write   = 1'b0;
                    hz.pipe_hold    = 1'b1;
                    hz.memwb_bubble = 1'b1;
                    if (state_q == ST_RUN) begin
                        state_d  = ST_MEM_WAIT;
                        to_cnt_d = TO_W'(1);
                    end else if (to_cnt_q == TO_W'(TIMEOUT)) begin
                        state_d = ST_ERR;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end else begin
                    state_d  = ST_RUN;
                    to_cnt_d = '0;
                    if (branch_taken) begin
                        // The IF/ID instruction is being flushed, so any
                        // load-use hazard it carries is irrelevant.
                        hz.pc_src       = 1'b1;
                        hz.ifid_flush   = 1'b1;
                        hz.idex_bubble  = 1'b1;
                        hz.exmem_bubble = 1'b1;
                    end else if (load_use) begin
                        hz.pc_write    = 1'b0;
                        hz.ifid_write  = 1'b0;
                        hz.idex_bubble = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = ST_RUN;
                to_cnt_d = '0;
            end
        endcase

        // During reset the pipeline free-runs so it flushes itself.
        if (!rst_n) begin
            hz.pc_write     = 1'b1;
            hz.ifid_write   = 1'b1;
            hz.ifid_flush   = 1'b0;
            hz.idex_bubble  = 1'b0;
            hz.exmem_bubble = 1'b0;
            hz.pipe_hold    = 1'b0;
            hz.memwb_bubble = 1'b0;
            hz.pc_src       = 1'b0;
            hz.mem_timeout  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!hz.pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (hz.pc_src && (flush_cnt_q != '1))    flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Directed test of pipeline_hazard_ctrl: reset, load-use, taken branch,
//   memory wait, timeout and priority of mem wait over branch. Inputs change
//   1 ns after the rising edge; the DUT state moves on the falling edge, so
//   the combinational controls are sampled mid-cycle between the two.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

    localparam int REG_W = 3;
    localparam int CNT_W = 16;

`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    pipeline_hazard_ctrl_if #(.REG_W(REG_W)) hz_if ();

    pipeline_hazard_ctrl #(
        .REG_W  (REG_W),
        .TIMEOUT(15),
        .TO_W   (4),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hz       (hz_if),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance to 1 ns after the next rising edge (previous negedge committed).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz_if.ifid_rs       = '0;
        hz_if.ifid_rt       = '0;
        hz_if.ifid_uses_rt  = 1'b0;
        hz_if.idex_mem_read = 1'b0;
        hz_if.idex_wr_reg   = '0;
        hz_if.exmem_branch  = 1'b0;
        hz_if.exmem_zero    = 1'b0;
        hz_if.exmem_mem_rd  = 1'b0;
        hz_if.exmem_mem_wr  = 1'b0;
        hz_if.mem_ready     = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        // ---------------- 1: reset with memory busy ----------------
        clear_inputs();
        rst_n = 1'b0;
        hz_if.exmem_mem_rd = 1'b1;
        tick();
        #1;
        check("rst_pc_write",    32'(hz_if.pc_write),    32'd1);
        check("rst_ifid_write",  32'(hz_if.ifid_write),  32'd1);
        check("rst_pipe_hold",   32'(hz_if.pipe_hold),   32'd0);
        check("rst_memwb_bub",   32'(hz_if.memwb_bubble),32'd0);
        tick();
        check("rst_mem_timeout", 32'(hz_if.mem_timeout), 32'd0);
        tick();
        rst_n = 1'b1;
        clear_inputs();
        #1;
        check("post_rst_pc_write",  32'(hz_if.pc_write),  32'd1);
        check("post_rst_pipe_hold", 32'(hz_if.pipe_hold), 32'd0);
        check("post_rst_stall_cnt", 32'(stall_cnt),       32'd0);
        check("post_rst_flush_cnt", 32'(flush_cnt),       32'd0);

        // ---------------- 2: load-use ----------------
        tick();
        hz_if.idex_mem_read = 1'b1;
        hz_if.idex_wr_reg   = 3'd3;
        hz_if.ifid_rt       = 3'd3;
        hz_if.ifid_rs       = 3'd1;
        hz_if.ifid_uses_rt  = 1'b1;
        #1;
        check("lu_rt_pc_write",   32'(hz_if.pc_write),    32'd0);
        check("lu_rt_ifid_write", 32'(hz_if.ifid_write),  32'd0);
        check("lu_rt_idex_bub",   32'(hz_if.idex_bubble), 32'd1);
        check("lu_rt_pc_src",     32'(hz_if.pc_src),      32'd0);
        tick();
        hz_if.idex_mem_read = 1'b0;   // bubble moved into ID/EX
        #1;
        check("lu_resolved_pc_write", 32'(hz_if.pc_write),    32'd1);
        check("lu_resolved_idex_bub", 32'(hz_if.idex_bubble), 32'd0);
        tick();
        hz_if.idex_mem_read = 1'b1;
        hz_if.ifid_uses_rt  = 1'b0;
        hz_if.ifid_rs       = 3'd5;
        #1;
        check("lu_no_rt_pc_write", 32'(hz_if.pc_write),    32'd1);
        check("lu_no_rt_idex_bub", 32'(hz_if.idex_bubble), 32'd0);
        tick();
        hz_if.idex_wr_reg = 3'd0;
        hz_if.ifid_rs     = 3'd0;
        #1;
        check("lu_r0_pc_write", 32'(hz_if.pc_write), 32'd0);

        // ---------------- 3: taken branch with load-use ----------------
        tick();
        hz_if.exmem_branch = 1'b1;
        hz_if.exmem_zero   = 1'b1;
        #1;
        check("br_pc_src",     32'(hz_if.pc_src),       32'd1);
        check("br_ifid_flush", 32'(hz_if.ifid_flush),   32'd1);
        check("br_idex_bub",   32'(hz_if.idex_bubble),  32'd1);
        check("br_exmem_bub",  32'(hz_if.exmem_bubble), 32'd1);
        check("br_pc_write",   32'(hz_if.pc_write),     32'd1);
        tick();
        hz_if.exmem_zero    = 1'b0;
        hz_if.idex_mem_read = 1'b0;
        #1;
        check("br_nt_pc_src",     32'(hz_if.pc_src),       32'd0);
        check("br_nt_ifid_flush", 32'(hz_if.ifid_flush),   32'd0);
        check("br_nt_idex_bub",   32'(hz_if.idex_bubble),  32'd0);
        check("br_nt_exmem_bub",  32'(hz_if.exmem_bubble), 32'd0);
        // Two load-use stall cycles and one taken branch so far.
        check("br_stall_cnt", 32'(stall_cnt), PERF ? 32'd2 : 32'd0);
        check("br_flush_cnt", 32'(flush_cnt), PERF ? 32'd1 : 32'd0);

        // ---------------- 4: memory wait, 3 cycles ----------------
        tick();
        do_reset();
        hz_if.exmem_mem_rd = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            #1;
            check($sformatf("mw_hold_%0d", i),     32'(hz_if.pipe_hold),    32'd1);
            check($sformatf("mw_memwb_%0d", i),    32'(hz_if.memwb_bubble), 32'd1);
            check($sformatf("mw_pc_write_%0d", i), 32'(hz_if.pc_write),     32'd0);
            tick();
        end
        hz_if.mem_ready = 1'b1;
        #1;
        check("mw_done_hold",     32'(hz_if.pipe_hold), 32'd0);
        check("mw_done_pc_write", 32'(hz_if.pc_write),  32'd1);
        tick();
        clear_inputs();
        #1;
        check("mw_run_pc_write", 32'(hz_if.pc_write), 32'd1);
        check("mw_stall_cnt",    32'(stall_cnt),      PERF ? 32'd3 : 32'd0);

        // ---------------- 6: mem wait beats taken branch ----------------
        tick();
        hz_if.exmem_mem_rd = 1'b1;
        hz_if.exmem_branch = 1'b1;
        hz_if.exmem_zero   = 1'b1;
        #1;
        check("prio_pc_src",     32'(hz_if.pc_src),     32'd0);
        check("prio_pipe_hold",  32'(hz_if.pipe_hold),  32'd1);
        check("prio_ifid_flush", 32'(hz_if.ifid_flush), 32'd0);
        tick();
        hz_if.mem_ready = 1'b1;   // in MEM_WAIT, access completes: branch acts
        #1;
        check("prio_done_pc_src", 32'(hz_if.pc_src),    32'd1);
        check("prio_done_hold",   32'(hz_if.pipe_hold), 32'd0);

        // ---------------- 5: timeout ----------------
        tick();
        do_reset();
        hz_if.exmem_mem_wr = 1'b1;
        // Edges 1..15 leave the counter at 1..15; only the 16th edge errors.
        for (int i = 1; i <= 16; i++) begin
            #1;
            check($sformatf("to_pre_%0d", i), 32'(hz_if.mem_timeout), 32'd0);
            tick();
        end
        #1;
        check("to_err_flag",     32'(hz_if.mem_timeout), 32'd1);
        check("to_err_pc_write", 32'(hz_if.pc_write),    32'd0);
        hz_if.mem_ready = 1'b1;
        #1;
        check("to_sticky_flag", 32'(hz_if.mem_timeout), 32'd1);
        check("to_sticky_hold", 32'(hz_if.pipe_hold),   32'd1);
        tick();
        clear_inputs();
        hz_if.exmem_branch = 1'b1;
        hz_if.exmem_zero   = 1'b1;
        #1;
        check("to_err_flag2",  32'(hz_if.mem_timeout), 32'd1);
        check("to_err_no_br",  32'(hz_if.pc_src),      32'd0);
        tick();
        do_reset();
        #1;
        check("to_cleared_flag",     32'(hz_if.mem_timeout), 32'd0);
        check("to_cleared_pc_write", 32'(hz_if.pc_write),    32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
